// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the data-memory port between core and DMA.
// Core has fixed priority; a starvation counter and a bounded lock mode give DMA its slots.
module dm_port_arbiter #(
  parameter int DMA_SIZE     = 17,
  parameter int DMD_SIZE     = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req,
  input  logic                c_wrb,
  input  logic [DMA_SIZE-1:0] c_add,
  input  logic [DMD_SIZE-1:0] c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  input  logic                d_req,
  input  logic                d_wrb,
  input  logic                d_lock,
  input  logic [DMA_SIZE-1:0] d_add,
  input  logic [DMD_SIZE-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DMD_SIZE-1:0] rdata,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt
);

  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [3:0] LM = 4'(LOCK_MAX);

  typedef enum logic {
    NORM = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [3:0]          lock_q, lock_d;
  logic                ph_v_q, ph_v_d;
  logic                ph_own_q, ph_own_d;
  logic                ph_wrb_q, ph_wrb_d;
  logic [DMD_SIZE-1:0] bc_q, bc_d;
  logic [3:0]          lock_inc;

  assign lock_inc = lock_q + 4'd1;

  // Grant decision: core first in NORM unless DMA is starved; DMA first in LOCK.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      unique case (state_q)
        NORM: begin
          if (c_req && d_req) begin
            if (starve_q == SL) d_gnt = 1'b1;
            else                c_gnt = 1'b1;
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
        end
        LOCK: begin
          d_gnt = d_req;
          c_gnt = c_req & ~d_req;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic for mode, starvation and lock-length counters.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    if (d_gnt || !d_req) begin
      starve_d = 4'd0;
    end else if (c_gnt && starve_q != SL) begin
      starve_d = starve_q + 4'd1;
    end
    unique case (state_q)
      NORM: begin
        if (d_gnt && d_lock && LM != 4'd1) begin
          state_d = LOCK;
          lock_d  = 4'd1;
        end
      end
      LOCK: begin
        if (!d_req) begin
          state_d = NORM;
          lock_d  = 4'd0;
        end else begin
          lock_d = lock_inc;
          if (!d_lock || lock_inc == LM) begin
            state_d  = NORM;
            lock_d   = 4'd0;
            starve_d = 4'd0;
          end
        end
      end
      default: ;
    endcase
  end

  // Address phase and data-phase capture of the winner.
  always_comb begin
    ps_dm_cslt = c_gnt | d_gnt;
    ps_dm_wrb  = (d_gnt & d_wrb) | (c_gnt & c_wrb);
    dg_dm_add  = '0;
    unique case (1'b1)
      d_gnt:   dg_dm_add = d_add;
      c_gnt:   dg_dm_add = c_add;
      default: dg_dm_add = '0;
    endcase
    ph_v_d   = ps_dm_cslt;
    ph_own_d = d_gnt;
    ph_wrb_d = ps_dm_wrb;
  end

  // Write data for the previous cycle's write grant; hold otherwise.
  always_comb begin
    bc_dt = bc_q;
    if (ph_v_q && ph_wrb_q) begin
      bc_dt = ph_own_q ? d_wdata : c_wdata;
    end
    bc_d     = bc_dt;
    c_rvalid = ph_v_q & ~ph_wrb_q & ~ph_own_q;
    d_rvalid = ph_v_q & ~ph_wrb_q & ph_own_q;
    rdata    = dm_bc_dt;
  end

  // State and phase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= NORM;
      starve_q <= 4'd0;
      lock_q   <= 4'd0;
      ph_v_q   <= 1'b0;
      ph_own_q <= 1'b0;
      ph_wrb_q <= 1'b0;
      bc_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      ph_v_q   <= ph_v_d;
      ph_own_q <= ph_own_d;
      ph_wrb_q <= ph_wrb_d;
      bc_q     <= bc_d;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed and random checks of dm_port_arbiter
// against a cycle-level reference model and a simple memory.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

  localparam int LIMIT = 4;
  localparam int LMAX  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_wrb, c_gnt, c_rvalid;
  logic [16:0] c_add;
  logic [15:0] c_wdata;
  logic        d_req, d_wrb, d_lock, d_gnt, d_rvalid;
  logic [16:0] d_add;
  logic [15:0] d_wdata;
  logic [15:0] rdata, bc_dt, dm_bc_dt;
  logic        ps_dm_cslt, ps_dm_wrb;
  logic [16:0] dg_dm_add;

  int ntest = 0;
  int nfail = 0;

  dm_port_arbiter #(
    .DMA_SIZE(17), .DMD_SIZE(16),
    .STARVE_LIMIT(LIMIT), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .reset(rst_n),
    .c_req(c_req), .c_wrb(c_wrb), .c_add(c_add),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_wrb(d_wrb), .d_lock(d_lock),
    .d_add(d_add), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .rdata(rdata),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
    .dg_dm_add(dg_dm_add), .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 16'h0123 + 16'h4000);
  endfunction

  // Memory: address latched with the grant, write data taken one cycle later.
  logic [15:0] hmem [256];
  logic        mem_init;
  logic        wpend;
  logic [7:0]  waddr, raddr;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) hmem[i] <= init_val(i);
      wpend <= 1'b0;
      raddr <= 8'd0;
    end else begin
      if (wpend) hmem[waddr] <= bc_dt;
      wpend <= ps_dm_cslt & ps_dm_wrb;
      waddr <= dg_dm_add[7:0];
      if (ps_dm_cslt && !ps_dm_wrb) raddr <= dg_dm_add[7:0];
    end
  end
  assign dm_bc_dt = hmem[raddr];

  // Reference model state.
  logic [15:0] refmem [256];
  bit          m_lock;
  int          m_starve, m_lcnt;
  bit          pv, pown, pwrb;
  logic [7:0]  paddr;
  logic [15:0] bc_hold;
  bit          ec, ed;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lock = 0; m_starve = 0; m_lcnt = 0;
    pv = 0; pown = 0; pwrb = 0; paddr = 0;
    bc_hold = 0; ec = 0; ed = 0;
  endtask

  // Mid-cycle: compare every output with the model, then advance the model.
  task automatic mid();
    logic        e_wrb;
    logic [16:0] e_add;
    logic [15:0] e_bc;
    #4;
    if (!rst_n) begin
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_cslt", ps_dm_cslt, 0);
      chk("rst_wrb", ps_dm_wrb, 0);
      chk("rst_add", dg_dm_add, 0);
      chk("rst_bc_dt", bc_dt, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      model_reset();
    end else begin
      ec = 0; ed = 0;
      if (!m_lock) begin
        if (c_req && d_req) begin
          if (m_starve == LIMIT) ed = 1; else ec = 1;
        end else begin
          ec = c_req; ed = d_req;
        end
      end else begin
        ed = d_req; ec = c_req && !d_req;
      end
      e_wrb = ed ? d_wrb : (ec ? c_wrb : 1'b0);
      e_add = ed ? d_add : (ec ? c_add : 17'd0);
      e_bc  = (pv && pwrb) ? (pown ? d_wdata : c_wdata) : bc_hold;
      chk("c_gnt", c_gnt, ec);
      chk("d_gnt", d_gnt, ed);
      chk("cslt", ps_dm_cslt, ec | ed);
      chk("wrb", ps_dm_wrb, e_wrb);
      chk("add", dg_dm_add, e_add);
      chk("c_rvalid", c_rvalid, pv && !pwrb && !pown);
      chk("d_rvalid", d_rvalid, pv && !pwrb && pown);
      chk("bc_dt", bc_dt, e_bc);
      if (pv && !pwrb) chk("rdata", rdata, refmem[paddr]);
      if (pv && pwrb) refmem[paddr] = e_bc;
      bc_hold = e_bc;
      pv = ec | ed; pown = ed; pwrb = e_wrb; paddr = e_add[7:0];
      if (ed || !d_req) m_starve = 0;
      else if (ec) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (!m_lock) begin
        if (ed && d_lock && LMAX > 1) begin
          m_lock = 1; m_lcnt = 1;
        end
      end else if (!d_req) begin
        m_lock = 0;
      end else begin
        m_lcnt++;
        if (!d_lock || m_lcnt == LMAX) begin
          m_lock = 0; m_starve = 0;
        end
      end
    end
  endtask

  task automatic idle();
    c_req = 0; d_req = 0; d_lock = 0;
  endtask

  initial begin
    int k;
    logic got_d;
    for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
    model_reset();
    rst_n = 0; mem_init = 1;
    c_req = 1; d_req = 1; c_wrb = 0; d_wrb = 0; d_lock = 0;
    c_add = 0; d_add = 0; c_wdata = 0; d_wdata = 0;
    adv();
    // reset holds everything quiet despite requests
    mid(); adv();
    mid(); adv();
    // core read of 0x0A right after release
    rst_n = 1; mem_init = 0;
    d_req = 0; c_req = 1; c_wrb = 0; c_add = 17'h0000A;
    mid();
    chk("first_add", dg_dm_add, 17'h0000A);
    adv();
    idle();
    mid();
    chk("first_rvalid", c_rvalid, 1);
    chk("first_rdata", rdata, init_val(10));
    adv();
    // contention without lock: C,C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      c_req = 1; d_req = 1; d_lock = 0; c_wrb = 0; d_wrb = 0;
      c_add = 17'(i); d_add = 17'(i + 40);
      mid();
      chk("starve_pattern", d_gnt, (i % 5) == 4);
      adv();
    end
    // core write then read same address
    idle(); mid(); adv();
    c_req = 1; c_wrb = 1; c_add = 17'h0000F;
    mid(); adv();
    c_wdata = 16'hFFEE; c_wrb = 0;
    mid();
    chk("wr_bc_dt", bc_dt, 16'hFFEE);
    adv();
    idle(); c_wdata = 16'h1234;
    mid();
    chk("wr_rd_rvalid", c_rvalid, 1);
    chk("wr_rd_rdata", rdata, 16'hFFEE);
    adv();
    // lock burst bounded at LMAX
    for (int i = 0; i < 14; i++) begin
      c_req = 1; d_req = 1; d_lock = 1; c_wrb = 0; d_wrb = 0;
      c_add = 17'(i + 60); d_add = 17'(i + 80);
      mid();
      chk("lock_pattern", d_gnt, i >= 4 && i <= 11);
      adv();
    end
    // DMA read then reset before its data phase
    idle(); mid(); adv();
    d_req = 1; d_wrb = 0; d_add = 17'h00020;
    mid(); adv();
    rst_n = 0; idle();
    mid();
    chk("rst_drop_rvalid", d_rvalid, 0);
    adv();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      c_req = 1; d_req = 1; d_lock = 0;
      mid();
      chk("post_rst_starve", d_gnt, i == 4);
      adv();
    end
    // DMA writes 1..4 to 0x10..0x13 interleaved with core reads
    idle(); mid(); adv();
    k = 0;
    for (int n = 0; n < 40 && k < 4; n++) begin
      c_req = 1; c_wrb = 0; c_add = 17'(8'h10 + $urandom_range(0, 3));
      d_req = 1; d_wrb = 1; d_lock = n[0]; d_add = 17'(8'h10 + k);
      mid();
      got_d = ed;
      adv();
      d_wdata = 16'($urandom);
      c_wdata = 16'($urandom);
      if (got_d) begin
        d_wdata = 16'(k + 1);
        k++;
      end
    end
    chk("dma_writes_done", k, 4);
    idle();
    for (int i = 0; i < 3; i++) begin mid(); adv(); end
    for (int i = 0; i < 4; i++) chk("mem_dma", hmem[8'h10 + i], 16'(i + 1));
    chk("mem_core", hmem[8'h0F], 16'hFFEE);
    // random traffic
    for (int n = 0; n < 500; n++) begin
      c_req = ($urandom % 4) != 0;
      d_req = ($urandom % 3) != 0;
      d_lock = ($urandom % 3) == 0;
      c_wrb = $urandom % 2;
      d_wrb = $urandom % 2;
      c_add = 17'($urandom % 256);
      d_add = 17'($urandom % 256);
      c_wdata = 16'($urandom);
      d_wdata = 16'($urandom);
      mid(); adv();
    end
    idle();
    for (int i = 0; i < 3; i++) begin mid(); adv(); end
    k = 0;
    for (int i = 0; i < 256; i++) if (hmem[i] !== refmem[i]) k++;
    chk("mem_final", k, 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port of the memory block between two requesters: the core pipeline (DAG/PS path) and a DMA/loader engine.
- Grants one single-cycle access per clock on ps_dm_cslt/ps_dm_wrb/dg_dm_add.
- Steers write data into the memory's execute+1 write phase and routes returned read data to the winning requester.
- Core has fixed priority; a starvation counter and a bounded DMA lock mode guarantee DMA progress.

Parameters:
DMA_SIZE, 17, DM address width
DMD_SIZE, 16, DM data width
STARVE_LIMIT, 4, consecutive contested core grants before DMA is forced a slot (legal range 1..15)
LOCK_MAX, 8, maximum consecutive DMA grants in lock mode (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
c_req  input  1  core access request, single-cycle transaction
c_wrb  input  1  core write (1) / read (0)
c_add  input  DMA_SIZE  core address
c_wdata  input  DMD_SIZE  core write data, driven the cycle after c_gnt
c_gnt  output  1  core granted this cycle (combinational)
c_rvalid  output  1  core read data valid on rdata
d_req  input  1  DMA request
d_wrb  input  1  DMA write/read
d_lock  input  1  DMA requests burst lock
d_add  input  DMA_SIZE  DMA address
d_wdata  input  DMD_SIZE  DMA write data, driven the cycle after d_gnt
d_gnt  output  1  DMA granted this cycle (combinational)
d_rvalid  output  1  DMA read data valid on rdata
rdata  output  DMD_SIZE  read data, equal to dm_bc_dt
ps_dm_cslt  output  1  to memory chip select
ps_dm_wrb  output  1  to memory write/read
dg_dm_add  output  DMA_SIZE  to memory address
bc_dt  output  DMD_SIZE  to memory write data
dm_bc_dt  input  DMD_SIZE  from memory read data

Behaviour:
- FSM states: NORM (core priority) and LOCK (DMA priority). Reset state is NORM; starve_cnt=0, lock_cnt=0, all phase registers=0.
- While reset is low: c_gnt=d_gnt=0, ps_dm_cslt=0, ps_dm_wrb=0, dg_dm_add=0, bc_dt=0, c_rvalid=d_rvalid=0.
- NORM grant rules:
  - Core only requesting: core wins.
  - DMA only requesting: DMA wins.
  - Both requesting: core wins unless starve_cnt==STARVE_LIMIT, in which case DMA wins.
- LOCK grant rules: DMA wins whenever d_req=1, otherwise core wins.
- At most one grant per cycle. The address phase is combinational: ps_dm_cslt=c_gnt|d_gnt, and wrb/address are muxed from the winner in the same cycle. With no grant, ps_dm_cslt=0 and wrb/address are 0.
- starve_cnt:
  - Increments when core wins a contested cycle (saturates at STARVE_LIMIT).
  - Clears when DMA is granted or when d_req=0.
- Transitions:
  - NORM->LOCK when DMA is granted with d_lock=1; lock_cnt is loaded with 1.
  - In LOCK, each DMA grant increments lock_cnt.
  - LOCK->NORM when d_req=0, d_lock=0, or lock_cnt==LOCK_MAX after a grant.
  - On LOCK_MAX exit, the next cycle in NORM grants core if c_req=1, even if starve_cnt would favour DMA; starve_cnt is cleared on this exit.
- Data phase: a registered phase vector {valid, owner, wrb} captures each grant.
  - In cycle N+1, bc_dt = owner's wdata when the N-grant was a write; otherwise bc_dt holds its last value.
  - Back-to-back write then read to the same address must see the written data via the memory's bypass, so bc_dt must carry the N write data during N+1.
- Read return: a read granted in cycle N asserts the owner's rvalid for exactly one cycle in N+1; rdata=dm_bc_dt combinationally. No rvalid is asserted for writes.
- Reset mid-transaction: all pending phase/rvalid state is dropped, and the FSM returns to NORM.

Test Plan:
- Reset low with c_req=d_req=1 -> no grants, ps_dm_cslt=0. Release reset with c_req only, c_wrb=0, c_add=0x0000A -> c_gnt=1, dg_dm_add=0x0000A, c_rvalid=1 the next cycle with rdata=memory[0x0A].
- c_req and d_req held high, no lock, STARVE_LIMIT=4 -> grant pattern C,C,C,C,D repeating; starve_cnt returns to 0 after each D.
- Core write 0xFFEE to 0x0000F in cycle N, core read 0x0000F in N+1 -> bc_dt=0xFFEE in N+1; rdata=0xFFEE with c_rvalid in N+2.
- DMA d_lock=1, d_req held, c_req held, LOCK_MAX=8 -> 8 consecutive d_gnt, then 1 c_gnt, then re-arbitration in NORM.
- DMA read granted in N, reset asserted in N+1 -> d_rvalid stays 0, FSM in NORM, starve_cnt=0 after release.
- Alternating d_wrb=1 writes (0x0001..0x0004 to addresses 0x10..0x13) under contention with core reads -> the memory file shows the exact data at each address, and each core read returns the correct data with c_rvalid only.
